hub_block_mover: RTL
====================

// Module: hub_block_mover
// PURPOSE
// - Hub-bus initiator that copies or fills a block of longs in hub memory.
// - Drives the same w/wb/a/d/q port that the hub memory responds to, and issues one transfer per granted bus slot (ena_bus).
// - Sits between a control source (cog or debug host) and the hub memory port.
// - Moves data without cog instruction overhead and reports completion and errors.
// PARAMETERS
// - ADDR_W  14  long-address width of the hub port; pointers wrap modulo 2**ADDR_W.
// - LEN_W   14  width of the block-length counter, in longs.
// PORTS
// - clk_cog  in   1       single clock; every register is clocked on posedge.
// - res      in   1       asynchronous, active-high reset.
// - start    in   1       request a new operation; sampled only in IDLE.
// - mode     in   1       0 = copy src->dst, 1 = fill dst with fill.
// - abort    in   1       cancels an operation in progress.
// - src      in   ADDR_W  source long address; used for copy only.
// - dst      in   ADDR_W  destination long address.
// - len      in   LEN_W   number of longs to move; 0 means no-op.
// - fill     in   32      fill pattern; used for fill only.
// - busy     out  1       high while in RD or WR.
// - done     out  1       one-cycle pulse when an operation completes.
// - err      out  1       sticky; set when any write targets a[13]=1 (ROM space).
// - ena_bus  in   1       bus slot grant; the hub memory acts on mem_* only in cycles where this is high.
// - mem_w    out  1       write strobe.
// - mem_wb   out  4       byte enables.
// - mem_a    out  ADDR_W  long address.
// - mem_d    out  32      write data.
// - mem_q    in   32      read data; valid from the cycle after the read slot until the next slot edge.
// BEHAVIOUR
// - States: IDLE, RD, WR, DONE. Reset is asynchronous and forces IDLE. After reset:
//   busy=0, done=0, err=0, mem_w=0, mem_wb=0, mem_a=0, mem_d=0, all internal pointers and counters = 0.
// - Bus outputs are decoded from registered state only, never from ena_bus:
//   - IDLE and DONE: all mem_* outputs = 0.
//   - RD: mem_a=sp, mem_w=0, mem_wb=0, mem_d=0.
//   - WR: mem_a=dp, mem_w=1, mem_wb=4'hF.
//     - Copy: mem_d=mem_q (combinational pass-through; mem_q holds the preceding read).
//     - Fill: mem_d=fill_r.
// - IDLE, start=1:
//   - Latch src->sp, dst->dp, len->cnt, fill->fill_r, mode->mode_r. Clear err.
//   - Next state: len==0 -> DONE; mode=0 -> RD; mode=1 -> WR.
//   - No bus access is made for len==0.
// - start outside IDLE is ignored and has no side effects.
// - RD: stay in RD until a cycle with ena_bus=1; that edge performs the read; next state WR.
// - WR: stay in WR until a cycle with ena_bus=1; that edge performs the write. On that edge:
//   - dp <= dp+1 (wraps modulo 2**ADDR_W); in copy mode also sp <= sp+1.
//   - cnt <= cnt-1.
//   - If dp[13]=1, set err. The write is still issued (the memory ignores it) and the operation continues.
//   - Next state: cnt==1 -> DONE; otherwise RD (copy) or WR (fill).
// - DONE: done=1 for exactly one cycle; next state IDLE. busy=0 in DONE.
// - Throughput with ena_bus every cycle: copy = 2 cycles per long, fill = 1 cycle per long.
//   With ena_bus every other cycle, both figures double.
// - abort=1 in RD or WR: next state IDLE, no done pulse. A slot coinciding with abort still completes its transfer.
//   Abort is ignored in IDLE and DONE.
// - Copy is always ascending. Overlap with dst in (src, src+len) replicates data forward; this is defined behaviour.
// - Reset mid-operation: all outputs go to 0 immediately; the partial block stays in memory.
// TESTING
// 1. Copy src=0x0010, dst=0x0100, len=3, ena_bus=1 every cycle.
//    -> mem_a sequence 0x010,0x100,0x011,0x101,0x012,0x102; dst holds the src longs; done pulses 7 cycles after start; err=0.
// 2. Same copy with ena_bus high every 2nd cycle -> identical memory contents; done pulses 13 cycles after start (+/-1 by slot phase).
// 3. Fill dst=0x1FFE, len=4, fill=0xDEADBEEF.
//    -> writes to 0x1FFE,0x1FFF,0x2000,0x2001; err rises after the 0x2000 write; RAM 0x1FFE/0x1FFF = 0xDEADBEEF; done=1.
// 4. len=0 with start -> done pulses 1 cycle later; mem_w never high; busy never high.
// 5. Copy len=8, abort after the 2nd write slot -> IDLE, no done, exactly 2 dst longs changed.
//    A start while busy is ignored (latched params unchanged).
// 6. res pulsed mid-fill between clock edges -> mem_w/busy/mem_a drop to 0 asynchronously.
//    A following fill at dst=0x3FFF, len=2 wraps to 0x0000, with err=1.

Source files
------------

// File: rtl/hub_block_mover.sv
// Hub-bus initiator that copies or fills a block of longs in hub memory,
// issuing one transfer per granted bus slot (ena_bus).
module hub_block_mover #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 14
) (
    input  logic              clk_cog,
    input  logic              res,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic [31:0]       fill,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              ena_bus,
    output logic              mem_w,
    output logic [3:0]        mem_wb,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_d,
    input  logic [31:0]       mem_q,
    output logic [1:0]        state_dbg
);

    // Writes with this address bit set land in ROM space and flag err.
    localparam int ROM_BIT = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r, state_nx;
    logic [ADDR_W-1:0] sp, dp;
    logic [LEN_W-1:0]  cnt;
    logic [31:0]       fill_r;
    logic              mode_r;
    logic              load, step;

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) state_r <= IDLE;
        else     state_r <= state_nx;
    end

    // Abort wins over slot progress, so an aborted final write never pulses done.
    always_comb begin
        state_nx = state_r;
        load     = 1'b0;
        step     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (len == '0)   state_nx = DONE;
                    else if (mode)   state_nx = WR;
                    else             state_nx = RD;
                end
            end
            RD: begin
                if (ena_bus) state_nx = WR;
                if (abort)   state_nx = IDLE;
            end
            WR: begin
                if (ena_bus) begin
                    step = 1'b1;
                    if (cnt == LEN_W'(1)) state_nx = DONE;
                    else if (mode_r)      state_nx = WR;
                    else                  state_nx = RD;
                end
                if (abort) state_nx = IDLE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            sp     <= '0;
            dp     <= '0;
            cnt    <= '0;
            fill_r <= '0;
            mode_r <= 1'b0;
            err    <= 1'b0;
        end else if (load) begin
            sp     <= src;
            dp     <= dst;
            cnt    <= len;
            fill_r <= fill;
            mode_r <= mode;
            err    <= 1'b0;
        end else if (step) begin
            dp  <= dp + ADDR_W'(1);
            cnt <= cnt - LEN_W'(1);
            if (!mode_r)    sp  <= sp + ADDR_W'(1);
            if (dp[ROM_BIT]) err <= 1'b1;
        end
    end

    // Bus outputs depend on registered state only; copy data passes mem_q straight through.
    always_comb begin
        mem_w  = 1'b0;
        mem_wb = 4'h0;
        mem_a  = '0;
        mem_d  = '0;
        case (state_r)
            RD: mem_a = sp;
            WR: begin
                mem_a  = dp;
                mem_w  = 1'b1;
                mem_wb = 4'hF;
                mem_d  = mode_r ? fill_r : mem_q;
            end
            default: ;
        endcase
    end

    assign busy      = (state_r == RD) || (state_r == WR);
    assign done      = (state_r == DONE);
    assign state_dbg = state_r;

endmodule
